sgdmac_ar_scheduler: RTL and testbench

//  Shares the single AXI AR/R channel pair among N_REQ SGDMAC read requesters (descriptor fetcher, read engine(s)).
//  - AR side: round-robin arbitration with a registered output stage.
//  - R side: beats are routed back by RID.
//  - Per-requester outstanding-burst counts are tracked and capped.
//  - Reports channel idle to the top-level done logic.

---
 rtl/sgdmac_ar_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_sgdmac_ar_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgdmac_ar_scheduler.sv
// Purpose : shares one AXI AR/R channel pair among N_REQ read requesters (round-robin AR, RID-routed R).
// Latency : requester arvalid -> arvalid_o 1 cycle; minimum AR spacing 2 cycles; R path combinational.
// Backpres: AR fields held in a register until arready_i; R backpressure follows the addressed requester's ready.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_ar*_i / req_arready_o     per-requester AR request fields (flattened) and one-hot capture strobe
//   ar*_o / arvalid_o / arready_i AXI AR channel (registered)
//   rid_i, rlast_i, rvalid_i      AXI R channel inputs, rready_o back to the slave
//   req_rvalid_o / req_rready_i   per-requester R handshake (data is broadcast outside this block)
//   idle_o                        registered: no pending AR and nothing outstanding
//   rid_err_o                     sticky protocol error (bad RID or retire with no outstanding burst)
// Option: define SGDMAC_AR_PRIO_EN to give requester 0 strict priority over the round-robin group.

module sgdmac_ar_scheduler #(
  parameter int N_REQ    = 2,
  parameter int ID_W     = 4,
  parameter int MAX_OUTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_arvalid_i,
  input  logic [N_REQ*32-1:0]  req_araddr_i,
  input  logic [N_REQ*4-1:0]   req_arlen_i,
  input  logic [N_REQ*3-1:0]   req_arsize_i,
  input  logic [N_REQ*2-1:0]   req_arburst_i,
  output logic [N_REQ-1:0]     req_arready_o,
  output logic [ID_W-1:0]      arid_o,
  output logic [31:0]          araddr_o,
  output logic [3:0]           arlen_o,
  output logic [2:0]           arsize_o,
  output logic [1:0]           arburst_o,
  output logic                 arvalid_o,
  input  logic                 arready_i,
  input  logic [ID_W-1:0]      rid_i,
  input  logic                 rlast_i,
  input  logic                 rvalid_i,
  output logic                 rready_o,
  output logic [N_REQ-1:0]     req_rvalid_o,
  input  logic [N_REQ-1:0]     req_rready_i,
  output logic                 idle_o,
  output logic                 rid_err_o
);

  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NO = (N_REQ > 1) ? (N_REQ - 1) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [GW-1:0]   r_last_grant;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   w_gnt;
  logic            w_any;
  logic            w_capture;
  logic            w_hs;
  logic [N_REQ-1:0] w_elig;

  logic [CW-1:0]   r_outs [N_REQ];
  logic [N_REQ-1:0] w_inc;
  logic [N_REQ-1:0] w_dec;
  logic [N_REQ-1:0] w_zero;
  logic            w_underflow;

  logic [N_REQ-1:0] w_rid_hit;
  logic            w_rid_ok;
  logic            w_retire;

  logic            r_arvalid;
  logic [ID_W-1:0] r_arid;
  logic [31:0]     r_araddr;
  logic [3:0]      r_arlen;
  logic [2:0]      r_arsize;
  logic [1:0]      r_arburst;
  logic            r_idle;
  logic            r_rid_err;

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_elig[k] = req_arvalid_i[k] && (r_outs[k] < CW'(MAX_OUTS));
      w_zero[k] = (r_outs[k] == '0);
    end
  end

  always_comb begin
    logic [GW-1:0] v_idx;
    w_any = 1'b0;
    w_gnt = '0;
    v_idx = '0;
`ifdef SGDMAC_AR_PRIO_EN
    // Requester 0 pre-empts; the rest rotate over indices 1..N_REQ-1 only.
    if (w_elig[0]) begin
      w_any = 1'b1;
    end else begin
      for (int i = 1; i < N_REQ; i++) begin
        v_idx = GW'(((int'(r_last_grant) - 1 + i) % NO) + 1);
        if (!w_any && w_elig[v_idx]) begin
          w_any = 1'b1;
          w_gnt = v_idx;
        end
      end
    end
`else
    // Search starts one past the previous winner, wrapping around.
    for (int i = 1; i <= N_REQ; i++) begin
      v_idx = GW'((int'(r_last_grant) + i) % N_REQ);
      if (!w_any && w_elig[v_idx]) begin
        w_any = 1'b1;
        w_gnt = v_idx;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)     w_state_nxt = S_ISSUE;
      S_ISSUE: if (arready_i) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture     = (r_state == S_IDLE) && w_any;
    w_hs          = (r_state == S_ISSUE) && arready_i;
    req_arready_o = '0;
    if (w_capture) req_arready_o[w_gnt] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // AR output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arvalid    <= 1'b0;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_arburst    <= '0;
      r_grant      <= '0;
      r_last_grant <= GW'(N_REQ - 1);
    end else if (w_capture) begin
      r_arvalid <= 1'b1;
      r_arid    <= ID_W'(w_gnt);
      r_araddr  <= req_araddr_i[int'(w_gnt)*32 +: 32];
      r_arlen   <= req_arlen_i[int'(w_gnt)*4 +: 4];
      r_arsize  <= req_arsize_i[int'(w_gnt)*3 +: 3];
      r_arburst <= req_arburst_i[int'(w_gnt)*2 +: 2];
      r_grant   <= w_gnt;
`ifdef SGDMAC_AR_PRIO_EN
      // Priority grants to requester 0 must not disturb the rotation of the others.
      if (w_gnt != '0) r_last_grant <= w_gnt;
`else
      r_last_grant <= w_gnt;
`endif
    end else if (w_hs) begin
      r_arvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // R routing by RID; unknown IDs are drained so the slave never stalls on them
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rid_hit = '0;
    rready_o  = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      if (rid_i == ID_W'(k)) begin
        w_rid_hit[k] = 1'b1;
        rready_o     = req_rready_i[k];
      end
    end
    req_rvalid_o = w_rid_hit & {N_REQ{rvalid_i}};
  end

  assign w_rid_ok = |w_rid_hit;
  assign w_retire = rvalid_i && rready_o && rlast_i && w_rid_ok;

  // ---------------------------------------------------------------------------
  // Outstanding-burst counters
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_inc[k] = w_hs && (r_grant == GW'(k));
      w_dec[k] = w_retire && w_rid_hit[k];
    end
    // A retire with nothing outstanding (and no same-cycle issue) is a slave protocol error.
    w_underflow = |(w_dec & ~w_inc & w_zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) r_outs[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (w_inc[k] && !w_dec[k])
          r_outs[k] <= r_outs[k] + CW'(1);
        else if (w_dec[k] && !w_inc[k] && !w_zero[k])
          r_outs[k] <= r_outs[k] - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle    <= 1'b0;
      r_rid_err <= 1'b0;
    end else begin
      r_idle <= (r_state == S_IDLE) && !(|req_arvalid_i) && (&w_zero);
      if ((rvalid_i && !w_rid_ok) || w_underflow) r_rid_err <= 1'b1;
    end
  end

  assign arvalid_o = r_arvalid;
  assign arid_o    = r_arid;
  assign araddr_o  = r_araddr;
  assign arlen_o   = r_arlen;
  assign arsize_o  = r_arsize;
  assign arburst_o = r_arburst;
  assign idle_o    = r_idle;
  assign rid_err_o = r_rid_err;

endmodule

// File: tb/tb_sgdmac_ar_scheduler.sv
module tb_sgdmac_ar_scheduler;

  localparam int NR  = 2;
  localparam int IDW = 4;
  localparam int MO  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_arvalid_i;
  logic [NR*32-1:0]  req_araddr_i;
  logic [NR*4-1:0]   req_arlen_i;
  logic [NR*3-1:0]   req_arsize_i;
  logic [NR*2-1:0]   req_arburst_i;
  logic [NR-1:0]     req_arready_o;
  logic [IDW-1:0]    arid_o;
  logic [31:0]       araddr_o;
  logic [3:0]        arlen_o;
  logic [2:0]        arsize_o;
  logic [1:0]        arburst_o;
  logic              arvalid_o;
  logic              arready_i;
  logic [IDW-1:0]    rid_i;
  logic              rlast_i;
  logic              rvalid_i;
  logic              rready_o;
  logic [NR-1:0]     req_rvalid_o;
  logic [NR-1:0]     req_rready_i;
  logic              idle_o;
  logic              rid_err_o;

  always #5 clk = ~clk;

  sgdmac_ar_scheduler #(.N_REQ(NR), .ID_W(IDW), .MAX_OUTS(MO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_arvalid_i (req_arvalid_i),
    .req_araddr_i  (req_araddr_i),
    .req_arlen_i   (req_arlen_i),
    .req_arsize_i  (req_arsize_i),
    .req_arburst_i (req_arburst_i),
    .req_arready_o (req_arready_o),
    .arid_o        (arid_o),
    .araddr_o      (araddr_o),
    .arlen_o       (arlen_o),
    .arsize_o      (arsize_o),
    .arburst_o     (arburst_o),
    .arvalid_o     (arvalid_o),
    .arready_i     (arready_i),
    .rid_i         (rid_i),
    .rlast_i       (rlast_i),
    .rvalid_i      (rvalid_i),
    .rready_o      (rready_o),
    .req_rvalid_o  (req_rvalid_o),
    .req_rready_i  (req_rready_i),
    .idle_o        (idle_o),
    .rid_err_o     (rid_err_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  ar_t         sb[$];
  int          id_log[$];

  // requester-side stimulus state
  int          pend     [NR];
  logic [31:0] nxt_addr [NR];
  logic [3:0]  lenv     [NR];

  // reference model state
  int          m_last;
  int          m_outs   [NR];
  bit          m_busy;
  int          m_busy_id;
  bit          m_err;
  bit          m_idle;
  int          iss_cnt  [NR];

  task automatic model_reset();
    sb.delete();
    m_last = NR - 1;
    m_busy = 1'b0;
    m_busy_id = 0;
    m_err  = 1'b0;
    m_idle = 1'b0;
    for (int k = 0; k < NR; k++) m_outs[k] = 0;
  endtask

  function automatic int pick(input logic [NR-1:0] el);
    int idx;
`ifdef SGDMAC_AR_PRIO_EN
    if (el[0]) return 0;
    for (int i = 1; i < NR; i++) begin
      idx = ((m_last - 1 + i) % (NR - 1)) + 1;
      if (el[idx]) return idx;
    end
`else
    for (int i = 1; i <= NR; i++) begin
      idx = (m_last + i) % NR;
      if (el[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic drive_fields(input int k);
    req_araddr_i[32*k +: 32] = nxt_addr[k];
    req_arlen_i[4*k +: 4]    = lenv[k];
    req_arsize_i[3*k +: 3]   = 3'(k + 1);
    req_arburst_i[2*k +: 2]  = 2'b01;
  endtask

  task automatic load_req(input int k, input int n, input logic [31:0] base, input logic [3:0] len);
    pend[k]     = n;
    nxt_addr[k] = base;
    lenv[k]     = len;
    drive_fields(k);
    req_arvalid_i[k] = (n > 0);
  endtask

  // One clock: compare DUT against the model at negedge, then advance the model past the edge.
  task automatic tick();
    logic [NR-1:0] el;
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_rv;
    int            g;
    int            rid;
    bit            exp_rr;
    bit            hs;
    bit            ret;
    bit            idle_nxt;
    ar_t           e;
    @(negedge clk);
    for (int k = 0; k < NR; k++) el[k] = req_arvalid_i[k] && (m_outs[k] < MO);
    g = m_busy ? -1 : pick(el);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ar_grant", req_arready_o, exp_rdy);
    check("arvalid", arvalid_o, m_busy);
    if (m_busy && sb.size() > 0) begin
      check("arid",    arid_o,    sb[0].id);
      check("araddr",  araddr_o,  sb[0].addr);
      check("arlen",   arlen_o,   sb[0].len);
      check("arsize",  arsize_o,  sb[0].size);
      check("arburst", arburst_o, sb[0].burst);
    end
    rid    = int'(rid_i);
    exp_rv = '0;
    exp_rr = 1'b1;
    if (rid < NR) begin
      exp_rv[rid] = rvalid_i;
      exp_rr      = req_rready_i[rid];
    end
    check("r_route", req_rvalid_o, exp_rv);
    check("rready",  rready_o, exp_rr);
    check("idle",    idle_o, m_idle);
    check("rid_err", rid_err_o, m_err);
    hs       = m_busy && arready_i;
    ret      = rvalid_i && exp_rr && rlast_i && (rid < NR);
    idle_nxt = !m_busy && (req_arvalid_i == '0);
    for (int k = 0; k < NR; k++) if (m_outs[k] != 0) idle_nxt = 1'b0;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (rvalid_i && rid >= NR) m_err = 1'b1;
      if (hs) begin
        m_outs[m_busy_id]++;
        iss_cnt[m_busy_id]++;
        id_log.push_back(m_busy_id);
        if (sb.size() > 0) void'(sb.pop_front());
        m_busy = 1'b0;
      end
      if (ret) begin
        if (m_outs[rid] > 0) m_outs[rid]--;
        else m_err = 1'b1;
      end
      if (g >= 0) begin
        e.id = g; e.addr = nxt_addr[g]; e.len = lenv[g];
        e.size = 3'(g + 1); e.burst = 2'b01;
        sb.push_back(e);
        m_busy = 1'b1;
        m_busy_id = g;
`ifdef SGDMAC_AR_PRIO_EN
        if (g > 0) m_last = g;
`else
        m_last = g;
`endif
        pend[g]--;
        nxt_addr[g] = nxt_addr[g] + 32'h100;
        drive_fields(g);
        if (pend[g] == 0) req_arvalid_i[g] = 1'b0;
      end
      m_idle = idle_nxt;
    end
  endtask

  task automatic drain(input int max_cyc);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < max_cyc) begin
      tick();
      n++;
      busy = m_busy || (sb.size() > 0);
      for (int k = 0; k < NR; k++) if (pend[k] > 0) busy = 1'b1;
    end
    check("drain_timeout", busy, 1'b0);
  endtask

  task automatic rbeat(input int id, input bit last);
    rvalid_i     = 1'b1;
    rid_i        = IDW'(id);
    rlast_i      = last;
    req_rready_i = '1;
    tick();
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rid_i    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[4];
    int base0;
    rst = 1'b1;
    req_arvalid_i = '0; req_araddr_i = '0; req_arlen_i = '0;
    req_arsize_i = '0;  req_arburst_i = '0;
    arready_i = 1'b0; rid_i = '0; rlast_i = 1'b0; rvalid_i = 1'b0; req_rready_i = '0;
    for (int k = 0; k < NR; k++) begin
      pend[k] = 0; nxt_addr[k] = '0; lenv[k] = '0; iss_cnt[k] = 0;
    end
    model_reset();
    repeat (2) tick();
    check("rst_arvalid", arvalid_o, 1'b0);
    check("rst_arid",    arid_o, 0);
    check("rst_idle",    idle_o, 1'b0);
    check("rst_riderr",  rid_err_o, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: lone request from requester 1, one-cycle AR latency
    arready_i = 1'b1;
    load_req(1, 1, 32'h1000, 4'd3);
    tick();
    check("t1_arvalid", arvalid_o, 1'b1);
    check("t1_arid",    arid_o, 1);
    check("t1_araddr",  araddr_o, 32'h1000);
    check("t1_arlen",   arlen_o, 3);
    drain(20);
    repeat (2) tick();
    check("t1_idle_busy", idle_o, 1'b0);
    rbeat(1, 1'b0);
    rbeat(1, 1'b1);
    repeat (2) tick();
    check("t1_idle_done", idle_o, 1'b1);

    // 2: two requesters contending
    id_log.delete();
    load_req(0, 2, 32'h2000, 4'd1);
    load_req(1, 2, 32'h3000, 4'd7);
    drain(40);
`ifdef SGDMAC_AR_PRIO_EN
    exp_seq = '{0, 0, 1, 1};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    check("t2_count", id_log.size(), 4);
    for (int i = 0; i < 4 && i < id_log.size(); i++) check("t2_seq", id_log[i], exp_seq[i]);
    rbeat(0, 1'b1); rbeat(1, 1'b1); rbeat(0, 1'b1); rbeat(1, 1'b1);
    repeat (2) tick();
    check("t2_idle", idle_o, 1'b1);

    // 3: outstanding cap on requester 0
    base0 = iss_cnt[0];
    load_req(0, 5, 32'h4000, 4'd0);
    repeat (16) tick();
    check("t3_capped", iss_cnt[0] - base0, MO);
    check("t3_no_grant", req_arready_o, '0);
    rbeat(0, 1'b1);
    drain(20);
    check("t3_resumed", iss_cnt[0] - base0, MO + 1);
    for (int i = 0; i < MO; i++) rbeat(0, 1'b1);
    repeat (2) tick();
    check("t3_idle", idle_o, 1'b1);

    // 4: issue and retire on the same counter in the same cycle
    load_req(1, 2, 32'h5000, 4'd2);
    drain(20);
    arready_i = 1'b0;
    load_req(1, 1, 32'h5800, 4'd2);
    tick();
    check("t4_issue", arvalid_o, 1'b1);
    arready_i = 1'b1;
    rbeat(1, 1'b1);
    repeat (2) tick();
    check("t4_busy", idle_o, 1'b0);
    rbeat(1, 1'b1);
    rbeat(1, 1'b1);
    repeat (2) tick();
    check("t4_idle",   idle_o, 1'b1);
    check("t4_no_err", rid_err_o, 1'b0);

    // 5: beat with an RID nobody owns
    rvalid_i = 1'b1; rid_i = IDW'(3); rlast_i = 1'b1; req_rready_i = '0;
    #1;
    check("t5_rready", rready_o, 1'b1);
    check("t5_rvalid", req_rvalid_o, '0);
    tick();
    rvalid_i = 1'b0; rlast_i = 1'b0; rid_i = '0; req_rready_i = '1;
    check("t5_err", rid_err_o, 1'b1);
    repeat (3) tick();
    check("t5_err_sticky", rid_err_o, 1'b1);
    check("t5_idle", idle_o, 1'b1);

    // 6: slave stalls AR, then reset
    arready_i = 1'b0;
    load_req(0, 1, 32'h6000, 4'd5);
    repeat (11) tick();
    check("t6_arvalid", arvalid_o, 1'b1);
    check("t6_araddr",  araddr_o, 32'h6000);
    check("t6_idle",    idle_o, 1'b0);
    req_arvalid_i = '0;
    for (int k = 0; k < NR; k++) pend[k] = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_arvalid", arvalid_o, 1'b0);
    check("t6_rst_arid",    arid_o, 0);
    check("t6_rst_araddr",  araddr_o, 0);
    check("t6_rst_arlen",   arlen_o, 0);
    check("t6_rst_arsize",  arsize_o, 0);
    check("t6_rst_arburst", arburst_o, 0);
    check("t6_rst_idle",    idle_o, 1'b0);
    check("t6_rst_err",     rid_err_o, 1'b0);
    repeat (3) tick();
    check("t6_idle_after", idle_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
